// File: rtl/alpha_razor_replay.sv
// Alpha recursion stage for the 8-state turbo trellis. Define ALPHA_RAZOR_SHADOW_EN to build the Razor
// shadow latches and the one-cycle replay/correction FSM; otherwise it is a plain registered recursion.
module alpha_razor_replay #(
   parameter int N          = 5,
   parameter int M          = 6,
   parameter int RAZOR_BITS = 2,
   parameter int CNT_W      = 8
) (
   input  logic                    Clock,
   input  logic                    nReset,
   input  logic                    Enable,
   input  logic                    Error_in,
   input  logic [7:1][M-1:0]       alpha_in_DFF,
   input  logic signed [N-1:0]     ba2,
   input  logic signed [M:0]       ba1ba3,
   input  logic signed [M:0]       ba1ba2ba3,
   output logic [7:1][M-1:0]       alpha_out_DFF,
   output logic                    Error_current,
   output logic [CNT_W-1:0]        Err_count
);

   localparam int DW = M + 3;
   typedef logic signed [M+1:0] sum_t;

   if (RAZOR_BITS < 1 || RAZOR_BITS > M) begin : g_bad_razor_bits
      $error("alpha_razor_replay: RAZOR_BITS must be within 1..M");
   end

   // Tie goes to the second operand.
   function automatic sum_t max_tie_y(input sum_t x, input sum_t y);
      if (x > y) return x;
      else       return y;
   endfunction

   function automatic logic [M-1:0] sat_m(input logic signed [DW-1:0] d);
      logic signed [DW-1:0] hi;
      logic signed [DW-1:0] lo;
      hi = {4'b0000, {(M-1){1'b0}} | {(M-1){1'b1}}};
      lo = {4'b1111, {(M-1){1'b0}}};
      if (d > hi)      return hi[M-1:0];
      else if (d < lo) return lo[M-1:0];
      else             return d[M-1:0];
   endfunction

   sum_t             a_s [1:7];
   sum_t             c_s [0:7];
   sum_t             g2_s;
   sum_t             g13_s;
   sum_t             g3_s;
   logic [7:1][M-1:0] next_s;
   logic             capture_s;

   // Candidate metrics and normalisation against state 0.
   always_comb begin
      g2_s  = sum_t'(ba2);
      g13_s = sum_t'(ba1ba3);
      g3_s  = sum_t'(ba1ba2ba3);
      for (int k = 1; k <= 7; k++) a_s[k] = sum_t'($signed(alpha_in_DFF[k]));
      c_s[0] = max_tie_y({(M+2){1'b0}}, a_s[1] + g3_s);
      c_s[1] = max_tie_y(a_s[2] + g13_s, a_s[3] + g2_s);
      c_s[2] = max_tie_y(a_s[4] + g2_s,  a_s[5] + g13_s);
      c_s[3] = max_tie_y(a_s[7],         a_s[6] + g3_s);
      c_s[4] = max_tie_y(g3_s,           a_s[1]);
      c_s[5] = max_tie_y(a_s[2] + g2_s,  a_s[3] + g13_s);
      c_s[6] = max_tie_y(a_s[4] + g13_s, a_s[5] + g2_s);
      c_s[7] = max_tie_y(a_s[6],         a_s[7] + g3_s);
      for (int k = 1; k <= 7; k++) next_s[k] = sat_m(DW'(c_s[k]) - DW'(c_s[0]));
   end

`ifdef ALPHA_RAZOR_SHADOW_EN
   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_CORRECT = 1'b1;

   logic [0:0]                   state_r;
   logic                         shadow_valid_r;
   logic                         cap_tog_r;
   logic                         neg_tog_r;
   logic                         open_s;
   logic                         mismatch_s;
   logic [CNT_W-1:0]             cnt_inc_s;
   logic [7:1][RAZOR_BITS-1:0]   shadow_r;

   // The toggle pair opens the shadow window from a capture edge until the following falling edge.
   assign open_s = cap_tog_r ^ neg_tog_r;

   // Shadow latches follow the late-settling MSBs while Clock is high after a capture.
   always_latch begin
      if (!nReset) begin
         shadow_r <= {(7*RAZOR_BITS){1'b0}};
      end else if (Clock && open_s) begin
         for (int k = 1; k <= 7; k++) shadow_r[k] <= next_s[k][M-1 -: RAZOR_BITS];
      end
   end

   // Falling-edge half of the window toggle pair.
   always_ff @(negedge Clock or negedge nReset) begin
      if (!nReset) neg_tog_r <= 1'b0;
      else         neg_tog_r <= cap_tog_r;
   end

   // Mismatch detection, capture qualification and saturating increment.
   always_comb begin
      mismatch_s = 1'b0;
      for (int k = 1; k <= 7; k++)
         mismatch_s = mismatch_s | (shadow_r[k] != alpha_out_DFF[k][M-1 -: RAZOR_BITS]);
      mismatch_s = mismatch_s & shadow_valid_r;
      capture_s  = (state_r == ST_RUN) && Enable && !Error_in && !mismatch_s;
      if (Err_count != {CNT_W{1'b1}}) cnt_inc_s = Err_count + {{(CNT_W-1){1'b0}}, 1'b1};
      else                            cnt_inc_s = Err_count;
   end

   // Metric register, replay FSM and correction counter.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         alpha_out_DFF  <= {(7*M){1'b0}};
         Error_current  <= 1'b0;
         Err_count      <= {CNT_W{1'b0}};
         state_r        <= ST_RUN;
         shadow_valid_r <= 1'b0;
         cap_tog_r      <= 1'b0;
      end else begin
         shadow_valid_r <= capture_s;
         cap_tog_r      <= cap_tog_r ^ capture_s;
         case (state_r)
            ST_RUN: begin
               if (mismatch_s) begin
                  for (int k = 1; k <= 7; k++) alpha_out_DFF[k][M-1 -: RAZOR_BITS] <= shadow_r[k];
                  Error_current <= 1'b1;
                  Err_count     <= cnt_inc_s;
                  state_r       <= ST_CORRECT;
               end else begin
                  if (capture_s) alpha_out_DFF <= next_s;
                  else           alpha_out_DFF <= alpha_out_DFF;
                  Error_current <= 1'b0;
                  state_r       <= ST_RUN;
               end
            end
            ST_CORRECT: begin
               Error_current <= 1'b0;
               state_r       <= ST_RUN;
            end
            default: begin
               Error_current <= 1'b0;
               state_r       <= ST_RUN;
            end
         endcase
      end
   end
`else
   assign capture_s     = Enable && !Error_in;
   assign Error_current = 1'b0;
   assign Err_count     = {CNT_W{1'b0}};

   // Plain registered recursion.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset)        alpha_out_DFF <= {(7*M){1'b0}};
      else if (capture_s) alpha_out_DFF <= next_s;
      else                alpha_out_DFF <= alpha_out_DFF;
   end
`endif

endmodule

// File: tb/tb_alpha_razor_replay.sv
// Scoreboard bench for alpha_razor_replay (default parameters), with or without ALPHA_RAZOR_SHADOW_EN.
module tb_alpha_razor_replay;

`ifdef ALPHA_RAZOR_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic              Clock;
   logic              nReset;
   logic              Enable;
   logic              Error_in;
   logic [7:1][5:0]   alpha_in_DFF;
   logic signed [4:0] ba2;
   logic signed [6:0] ba1ba3;
   logic signed [6:0] ba1ba2ba3;
   logic [7:1][5:0]   alpha_out_DFF;
   logic              Error_current;
   logic [7:0]        Err_count;

   alpha_razor_replay dut (
      .Clock(Clock), .nReset(nReset), .Enable(Enable), .Error_in(Error_in),
      .alpha_in_DFF(alpha_in_DFF), .ba2(ba2), .ba1ba3(ba1ba3), .ba1ba2ba3(ba1ba2ba3),
      .alpha_out_DFF(alpha_out_DFF), .Error_current(Error_current), .Err_count(Err_count)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [7:1][5:0] alpha;
      logic            err;
      logic [7:0]      cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_bad = 0;

   // stimulus values as plain integers
   int ia [1:7];
   int ig2, ig13, ig3;

   // reference model state
   logic [7:1][5:0] m_alpha;
   logic [7:1][1:0] m_sh;
   int              m_cnt;
   bit              m_corr;
   bit              m_sv;

   function automatic int mx(int x, int y);
      return (x > y) ? x : y;
   endfunction

   function automatic int sat6(int v);
      return (v > 31) ? 31 : ((v < -32) ? -32 : v);
   endfunction

   function automatic logic [7:1][5:0] model_next();
      int c [0:7];
      logic [7:1][5:0] r;
      c[0] = mx(0, ia[1] + ig3);
      c[1] = mx(ia[2] + ig13, ia[3] + ig2);
      c[2] = mx(ia[4] + ig2, ia[5] + ig13);
      c[3] = mx(ia[7], ia[6] + ig3);
      c[4] = mx(ig3, ia[1]);
      c[5] = mx(ia[2] + ig2, ia[3] + ig13);
      c[6] = mx(ia[4] + ig13, ia[5] + ig2);
      c[7] = mx(ia[6], ia[7] + ig3);
      for (int k = 1; k <= 7; k++) r[k] = 6'(sat6(c[k] - c[0]));
      return r;
   endfunction

   function automatic logic [7:1][1:0] msbs(input logic [7:1][5:0] v);
      logic [7:1][1:0] r;
      for (int k = 1; k <= 7; k++) r[k] = v[k][5:4];
      return r;
   endfunction

   task automatic drive();
      for (int k = 1; k <= 7; k++) alpha_in_DFF[k] = 6'(ia[k]);
      ba2       = 5'(ig2);
      ba1ba3    = 7'(ig13);
      ba1ba2ba3 = 7'(ig3);
   endtask

   task automatic model_reset();
      m_alpha = '0;
      m_sh    = '0;
      m_cnt   = 0;
      m_corr  = 1'b0;
      m_sv    = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, req);
      end
   endtask

   // One clock: drive at the falling edge, push the expected response, return at the rising edge.
   task automatic cycle(input bit en, input bit ei);
      exp_t e;
      bit   err;
      @(negedge Clock);
      Enable   = en;
      Error_in = ei;
      drive();
      err = 1'b0;
      if (SHADOW && m_corr) begin
         m_corr = 1'b0;
         m_sv   = 1'b0;
      end else if (SHADOW && m_sv && (m_sh != msbs(m_alpha))) begin
         for (int k = 1; k <= 7; k++) m_alpha[k][5:4] = m_sh[k];
         err    = 1'b1;
         if (m_cnt < 255) m_cnt++;
         m_corr = 1'b1;
         m_sv   = 1'b0;
      end else if (en && !ei) begin
         m_alpha = model_next();
         m_sh    = msbs(m_alpha);
         m_sv    = SHADOW;
      end else begin
         m_sv = 1'b0;
      end
      e.alpha = m_alpha;
      e.err   = err;
      e.cnt   = 8'(m_cnt);
      exp_q.push_back(e);
      @(posedge Clock);
   endtask

   // Change g13 while Clock is high after a capture; the shadow sees the new value.
   task automatic late_g13(input int v);
      #1;
      ig13 = v;
      drive();
      if (m_sv) m_sh = msbs(model_next());
   endtask

   task automatic set_inputs(input int a1, a2, a3, a4, a5, a6, a7, g2, g13, g3);
      ia[1] = a1; ia[2] = a2; ia[3] = a3; ia[4] = a4; ia[5] = a5; ia[6] = a6; ia[7] = a7;
      ig2 = g2; ig13 = g13; ig3 = g3;
   endtask

   task automatic randomize_inputs();
      for (int k = 1; k <= 7; k++) ia[k] = int'($urandom_range(0, 63)) - 32;
      ig2  = int'($urandom_range(0, 31)) - 16;
      ig13 = int'($urandom_range(0, 127)) - 64;
      ig3  = int'($urandom_range(0, 127)) - 64;
   endtask

   // Monitor: pops one expectation per rising edge while the scoreboard holds any.
   initial begin
      forever begin
         @(posedge Clock);
         #1;
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if (alpha_out_DFF !== mon_e.alpha || Error_current !== mon_e.err || Err_count !== mon_e.cnt) begin
               n_bad++;
               $display("FAIL scoreboard @%0t: alpha=%h err=%b cnt=%0d, want alpha=%h err=%b cnt=%0d",
                        $time, alpha_out_DFF, Error_current, Err_count, mon_e.alpha, mon_e.err, mon_e.cnt);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:1][5:0] held;
      logic [7:1][5:0] e1;
      nReset   = 1'b0;
      Enable   = 1'b0;
      Error_in = 1'b0;
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive();
      model_reset();
      #3;
      chk("reset_alpha", 64'(alpha_out_DFF), 64'd0);
      chk("reset_err", 64'(Error_current), 64'd0);
      chk("reset_cnt", 64'(Err_count), 64'd0);
      @(negedge Clock);
      nReset = 1'b1;
      cycle(1'b0, 1'b0);

      // basic vector
      set_inputs(0, 0, 0, 0, 0, 0, 0, 3, 5, -4);
      cycle(1'b1, 1'b0);
      #1;
      e1 = {6'd0, 6'd5, 6'd5, 6'd0, 6'd0, 6'd5, 6'd5};
      chk("basic_alpha", 64'(alpha_out_DFF), 64'(e1));

      // positive saturation
      set_inputs(-32, 31, 0, 0, 0, 0, 0, 0, 63, -64);
      cycle(1'b1, 1'b0);
      #1;
      chk("pos_sat_a1", 64'(alpha_out_DFF[1]), 64'(6'd31));

      // negative saturation
      set_inputs(31, 0, 0, 0, 0, 0, 0, 0, 0, 63);
      cycle(1'b1, 1'b0);
      #1;
      chk("neg_sat_a1", 64'(alpha_out_DFF[1]), 64'(6'b100000));
      chk("neg_sat_a4", 64'(alpha_out_DFF[4]), 64'(6'b100001));

      // Error_in holds the stage for three cycles
      held = alpha_out_DFF;
      for (int i = 0; i < 3; i++) begin
         randomize_inputs();
         cycle(1'b1, 1'b1);
      end
      #1;
      chk("hold_alpha", 64'(alpha_out_DFF), 64'(held));
      set_inputs(0, 0, 0, 0, 0, 0, 0, 3, 5, -4);
      cycle(1'b1, 1'b0);
      #1;
      chk("resume_alpha", 64'(alpha_out_DFF), 64'(e1));

      // late-arriving g13 after a capture of [1] = 5
      cycle(1'b1, 1'b0);
      late_g13(20);
      cycle(1'b1, 1'b0);
      #1;
      chk("late_a1", 64'(alpha_out_DFF[1]), SHADOW ? 64'(6'd21) : 64'(6'd20));
      chk("late_err", 64'(Error_current), SHADOW ? 64'd1 : 64'd0);
      chk("late_cnt", 64'(Err_count), SHADOW ? 64'd1 : 64'd0);
      cycle(1'b1, 1'b0);
      #1;
      chk("stall_err", 64'(Error_current), 64'd0);
      chk("stall_a1", 64'(alpha_out_DFF[1]), SHADOW ? 64'(6'd21) : 64'(6'd20));
      cycle(1'b1, 1'b0);

      // reset asserted during the correction cycle
      set_inputs(0, 0, 0, 0, 0, 0, 0, 3, 5, -4);
      cycle(1'b1, 1'b0);
      late_g13(20);
      cycle(1'b1, 1'b0);
      #3;
      nReset = 1'b0;
      model_reset();
      #1;
      chk("midrst_alpha", 64'(alpha_out_DFF), 64'd0);
      chk("midrst_err", 64'(Error_current), 64'd0);
      chk("midrst_cnt", 64'(Err_count), 64'd0);
      @(negedge Clock);
      @(negedge Clock);
      nReset = 1'b1;

      // randomized traffic with occasional late g13 changes
      for (int i = 0; i < 300; i++) begin
         randomize_inputs();
         cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2);
         if ($urandom_range(0, 9) < 2) late_g13(int'($urandom_range(0, 127)) - 64);
      end
      cycle(1'b0, 1'b0);
      #2;
      chk("drain", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
